// File: rtl/cnt_bcd_convert.sv
`default_nettype none
// ============================================================================
// Module      : cnt_bcd_convert
// Description : Sequential binary-to-decimal converter (shift-add-3 / double
//               dabble). Converts one BIN_W-bit count per request into packed
//               BCD and ASCII characters for the LCD data line.
//               Optional build macro CNT_BCD_LZB_EN: leading zero digits of
//               the ASCII output are blanked to spaces (units digit always
//               shown); the BCD output is unaffected.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_bcd_convert #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iStart,
  input  logic [BIN_W-1:0]      iBin,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [4*DIGITS-1:0]   oBcd,
  output logic [8*DIGITS-1:0]   oChar_data
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(BIN_W - 1);

  // Decimal digits needed for the largest BIN_W-bit value: ceil(BIN_W*log10(2)).
  localparam int c_MIN_DIGITS = (BIN_W * 30103 + 99999) / 100000;

`ifdef CNT_BCD_LZB_EN
  // Idle pattern with blanking: spaces everywhere except a units '0'.
  localparam logic [8*DIGITS-1:0] c_RST_CHARS = {{(DIGITS-1){8'h20}}, 8'h30};
`else
  localparam logic [8*DIGITS-1:0] c_RST_CHARS = {DIGITS{8'h30}};
`endif

  // Reject configurations where DIGITS cannot hold the full input range.
  generate
    if (c_MIN_DIGITS > DIGITS) begin : g_digits_too_small
      $error("cnt_bcd_convert: DIGITS=%0d too small for BIN_W=%0d (need %0d)",
             DIGITS, BIN_W, c_MIN_DIGITS);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                r_state;
  logic [BIN_W-1:0]      r_bin_sr;
  logic [4*DIGITS-1:0]   r_bcd_sr;
  logic [c_CNT_W-1:0]    r_bitcnt;
  logic                  r_busy;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [8*DIGITS-1:0]   r_chars;

  logic [4*DIGITS-1:0]   w_bcd_adj;
  logic [8*DIGITS-1:0]   w_chars;
  logic                  w_digits_ok;
  logic                  w_seen;
  logic [3:0]            w_digit;

  // --------------------------------------------------------------------------
  // Add-3 correction: any BCD digit >= 5 is pre-adjusted so that the
  // following left shift produces a correct decimal carry.
  // --------------------------------------------------------------------------
  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      logic [3:0] w_nib;
      assign w_nib = r_bcd_sr[4*d +: 4];
      assign w_bcd_adj[4*d +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end
  endgenerate

  // Encode the finished BCD digits into ASCII (optionally blanking leading zeros).
  always_comb begin
    w_chars     = '0;
    w_digits_ok = 1'b1;
    w_seen      = 1'b0;
    w_digit     = 4'd0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_digit = r_bcd_sr[4*d +: 4];
      if (w_digit > 4'd9) begin
        w_digits_ok = 1'b0;
      end
      if ((w_digit != 4'd0) || (d == 0)) begin
        w_seen = 1'b1;
      end
`ifdef CNT_BCD_LZB_EN
      w_chars[8*d +: 8] = w_seen ? (8'h30 + {4'h0, w_digit}) : 8'h20;
`else
      w_chars[8*d +: 8] = 8'h30 + {4'h0, w_digit};
`endif
    end
  end

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= S_IDLE;
      r_bin_sr <= '0;
      r_bcd_sr <= '0;
      r_bitcnt <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
      r_chars  <= c_RST_CHARS;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_bin_sr <= iBin;
            r_bcd_sr <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // One input bit enters the BCD register per edge, MSB first.
          r_bcd_sr <= {w_bcd_adj[4*DIGITS-2:0], r_bin_sr[BIN_W-1]};
          r_bin_sr <= {r_bin_sr[BIN_W-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == c_LAST_BIT) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // Publish the complete result in one step so no partial value is seen.
          r_bcd   <= r_bcd_sr;
          r_chars <= w_chars;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oBusy      = r_busy;
  assign oDone      = r_done;
  assign oBcd       = r_bcd;
  assign oChar_data = r_chars;

  // A shift-add-3 register can never hold a digit above 9.
  a_digit_range: assert property (@(posedge iCLK) disable iff (!iRST_N)
                                  (r_state == S_FINISH) |-> w_digits_ok);

endmodule
`default_nettype wire
